// File: rtl/cgra_cfg_loader.sv
// Streams FH configuration frames into one CGRA tile's config port, pulsing the
// matching one-hot strobe bit with programmable setup/pulse/hold spacing.
module cgra_cfg_loader #(
  parameter int FW    = 32,
  parameter int FH    = 2,
  parameter int SETUP = 1,
  parameter int PULSE = 1,
  parameter int HOLD  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [FW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [FW-1:0] cfg_data,
  output logic [FH-1:0] cfg_strb,
  output logic          cfg_clr,
  output logic          busy,
  output logic          done
);

  localparam int TMAX0 = (SETUP > PULSE) ? SETUP : PULSE;
  localparam int TMAX  = (TMAX0 > HOLD) ? TMAX0 : HOLD;
  localparam int CW    = $clog2(TMAX + 1);
  localparam int IW    = (FH > 1) ? $clog2(FH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] data_q, data_d;
  logic [FH-1:0] strb_q, strb_d;
  logic          clr_q, clr_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Outputs are computed for the upcoming state so every port is a flop.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    strb_d  = strb_q;
    clr_d   = clr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WAIT;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          clr_d   = 1'b1;
          ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (s_valid) begin
          data_d  = s_data;
          state_d = S_SETUP;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP - 1)) begin
          state_d = S_STROBE;
          cnt_d   = '0;
          strb_d  = FH'(1) << idx_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == CW'(PULSE - 1)) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          strb_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD - 1)) begin
          cnt_d = '0;
          if (idx_q == IW'(FH - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            clr_d   = 1'b0;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_WAIT;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      clr_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      clr_q   <= clr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign s_ready  = ready_q;
  assign cfg_data = data_q;
  assign cfg_strb = strb_q;
  assign cfg_clr  = clr_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
